count_frame_tx: RTL and testbench

- Downstream stage of the four-channel pulse counter (four 16-bit counts plus the en_count gate).
- When a measurement window closes (falling edge of en_count), takes a snapshot of the four counts.
- Transmits the snapshot as a fixed 10-byte UART 8N1 frame with header and XOR checksum, for host readout.
- Ignores gate closures that occur while a frame is still being sent, and flags them.

---
 rtl/count_frame_tx.sv | 235 +++++++++++++++++++++++
 tb/tb_count_frame_tx.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/count_frame_tx.sv
// count_frame_tx
// Takes a snapshot of four 16-bit pulse counts when the measurement gate
// closes (falling edge of en_count) and sends it to the host as a 10-byte
// UART 8N1 frame: HEADER, count1..count4 (high byte first, each byte LSB
// first on the wire), then an XOR checksum over the nine preceding bytes.
//
// Ports:
//   clk         system clock
//   rst         asynchronous, active-high reset; aborts any frame in flight
//   en_count    measurement gate, synchronous to clk
//   count1..4   channel counts, sampled one cycle after the gate closes
//   tx          UART serial output, idles high
//   busy        high from the gate closure until the frame completes
//   frame_done  one-cycle pulse when the final stop bit completes
//   overrun     sticky: a gate closure arrived while busy and was dropped
module count_frame_tx #(
  parameter int         CLK_FREQ = 100_000_000,
  parameter int         BAUD     = 115200,
  parameter logic [7:0] HEADER   = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_count,
  input  logic [15:0] count1,
  input  logic [15:0] count2,
  input  logic [15:0] count3,
  input  logic [15:0] count4,
  output logic        tx,
  output logic        busy,
  output logic        frame_done,
  output logic        overrun
);

  // Must come out >= 2 for the bit timer to make sense.
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int TIMER_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0] LAST_BYTE = 4'd9;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CAPTURE = 3'd1,
    START   = 3'd2,
    DATA    = 3'd3,
    STOP    = 3'd4
  } state_t;

  state_t               state_r;
  state_t               state_next_s;
  logic                 en_d_r;
  logic                 fall_s;
  logic                 accept_s;
  logic                 tick_s;
  logic                 end_s;
  logic                 end_r;
  logic [63:0]          snap_in_s;
  logic [63:0]          snapshot_r;
  logic [7:0]           checksum_r;
  logic [3:0]           byte_idx_r;
  logic [2:0]           bit_idx_r;
  logic [TIMER_W-1:0]   timer_r;
  logic [7:0]           cur_byte_s;
  logic                 tx_s;
  logic                 tx_r;
  logic                 busy_r;
  logic                 frame_done_r;
  logic                 overrun_r;

  // XOR of the header and the eight snapshot bytes.
  function automatic logic [7:0] frame_checksum(input logic [63:0] snap);
    logic [7:0] acc;
    acc = HEADER;
    for (int i = 0; i < 8; i++) begin
      acc = acc ^ snap[8*i +: 8];
    end
    return acc;
  endfunction

  // Byte at position idx of the frame.
  function automatic logic [7:0] frame_byte(input logic [3:0] idx,
                                            input logic [63:0] snap,
                                            input logic [7:0] csum);
    logic [7:0] b;
    case (idx)
      4'd0:    b = HEADER;
      4'd1:    b = snap[63:56];
      4'd2:    b = snap[55:48];
      4'd3:    b = snap[47:40];
      4'd4:    b = snap[39:32];
      4'd5:    b = snap[31:24];
      4'd6:    b = snap[23:16];
      4'd7:    b = snap[15:8];
      4'd8:    b = snap[7:0];
      4'd9:    b = csum;
      default: b = 8'hFF;
    endcase
    return b;
  endfunction

  assign snap_in_s  = {count1, count2, count3, count4};
  assign fall_s     = en_d_r & ~en_count;
  // busy_r low implies the FSM is in IDLE, so this is the only way out of IDLE.
  assign accept_s   = fall_s & ~busy_r;
  assign tick_s     = (timer_r == TIMER_LAST);
  assign cur_byte_s = frame_byte(byte_idx_r, snapshot_r, checksum_r);

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic and end-of-frame detection.
  always_comb begin
    state_next_s = state_r;
    end_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) state_next_s = CAPTURE;
        else          state_next_s = IDLE;
      end
      CAPTURE: begin
        state_next_s = START;
      end
      START: begin
        if (tick_s) state_next_s = DATA;
        else        state_next_s = START;
      end
      DATA: begin
        if (tick_s && (bit_idx_r == 3'd7)) state_next_s = STOP;
        else                               state_next_s = DATA;
      end
      STOP: begin
        if (tick_s) begin
          if (byte_idx_r == LAST_BYTE) begin
            state_next_s = IDLE;
            end_s        = 1'b1;
          end else begin
            state_next_s = START;
          end
        end else begin
          state_next_s = STOP;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Line level implied by the current state; registered into tx_r below.
  always_comb begin
    tx_s = 1'b1;
    case (state_r)
      IDLE:    tx_s = 1'b1;
      CAPTURE: tx_s = 1'b1;
      START:   tx_s = 1'b0;
      DATA:    tx_s = cur_byte_s[bit_idx_r];
      STOP:    tx_s = 1'b1;
      default: tx_s = 1'b1;
    endcase
  end

  // Gate delay, snapshot capture, byte/bit indices and baud timer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_d_r     <= 1'b0;
      snapshot_r <= 64'd0;
      checksum_r <= 8'd0;
      byte_idx_r <= 4'd0;
      bit_idx_r  <= 3'd0;
      timer_r    <= {TIMER_W{1'b0}};
    end else begin
      en_d_r <= en_count;
      case (state_r)
        CAPTURE: begin
          // Sampled one cycle after the fall so the last increment has landed.
          snapshot_r <= snap_in_s;
          checksum_r <= frame_checksum(snap_in_s);
          byte_idx_r <= 4'd0;
          bit_idx_r  <= 3'd0;
          timer_r    <= {TIMER_W{1'b0}};
        end
        START: begin
          bit_idx_r <= 3'd0;
          timer_r   <= tick_s ? {TIMER_W{1'b0}} : timer_r + TIMER_W'(1);
        end
        DATA: begin
          if (tick_s) bit_idx_r <= bit_idx_r + 3'd1;
          else        bit_idx_r <= bit_idx_r;
          timer_r <= tick_s ? {TIMER_W{1'b0}} : timer_r + TIMER_W'(1);
        end
        STOP: begin
          if (tick_s && (byte_idx_r != LAST_BYTE)) byte_idx_r <= byte_idx_r + 4'd1;
          else                                     byte_idx_r <= byte_idx_r;
          timer_r <= tick_s ? {TIMER_W{1'b0}} : timer_r + TIMER_W'(1);
        end
        default: begin
          timer_r <= {TIMER_W{1'b0}};
        end
      endcase
    end
  end

  // Registered outputs. tx lags the FSM by one cycle, so the first start bit
  // appears two edges after the fall; end_r adds the same lag to frame_done
  // and the busy release so they line up with the end of the last stop bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_r         <= 1'b1;
      end_r        <= 1'b0;
      frame_done_r <= 1'b0;
      busy_r       <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      tx_r         <= tx_s;
      end_r        <= end_s;
      frame_done_r <= end_r;
      if (accept_s)  busy_r <= 1'b1;
      else if (end_r) busy_r <= 1'b0;
      else           busy_r <= busy_r;
      if (fall_s && busy_r) overrun_r <= 1'b1;
      else                  overrun_r <= overrun_r;
    end
  end

  assign tx         = tx_r;
  assign busy       = busy_r;
  assign frame_done = frame_done_r;
  assign overrun    = overrun_r;

endmodule

// File: tb/tb_count_frame_tx.sv
// Self-checking bench for count_frame_tx at 10 clks/bit (1000 clks/frame).
// A UART receiver decodes tx into a byte queue and logs start-bit edge
// cycles; expected frames are built from the counts by plain arithmetic.
module tb_count_frame_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_count;
  logic [15:0] count1, count2, count3, count4;
  logic        tx, busy, frame_done, overrun;

  count_frame_tx #(
    .CLK_FREQ(1_000_000),
    .BAUD    (100_000),
    .HEADER  (8'hA5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en_count  (en_count),
    .count1    (count1),
    .count2    (count2),
    .count3    (count3),
    .count4    (count4),
    .tx        (tx),
    .busy      (busy),
    .frame_done(frame_done),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // Number of rising edges so far; at a falling edge it names the edge just past.
  int pcyc = 0;
  always @(posedge clk) pcyc <= pcyc + 1;

  logic [7:0] byte_q[$];
  int         start_q[$];
  int         done_cnt = 0;
  int         done_t   = 0;
  int         stop_err = 0;
  int         n_cmp    = 0;
  int         n_bad    = 0;
  logic [7:0] exp_f[10];

  // Receiver: samples mid-bit on falling edges.
  initial begin : monitor
    logic       rx_busy;
    int         rx_cnt;
    logic [7:0] rx_byte;
    logic       tx_prev;
    rx_busy = 1'b0;
    rx_cnt  = 0;
    rx_byte = 8'd0;
    tx_prev = 1'b1;
    forever begin
      @(negedge clk);
      if (frame_done === 1'b1) begin
        done_cnt++;
        done_t = pcyc;
      end
      if (rst !== 1'b0) begin
        rx_busy = 1'b0;
        tx_prev = 1'b1;
      end else begin
        if (!rx_busy) begin
          if (tx_prev && !tx) begin
            rx_busy = 1'b1;
            rx_cnt  = 0;
            rx_byte = 8'd0;
            start_q.push_back(pcyc);
          end
        end else begin
          rx_cnt++;
          if (rx_cnt >= 15 && rx_cnt <= 85 && (rx_cnt % 10) == 5)
            rx_byte[(rx_cnt - 15) / 10] = tx;
          if (rx_cnt == 95) begin
            if (!tx) stop_err++;
            byte_q.push_back(rx_byte);
            rx_busy = 1'b0;
          end
        end
        tx_prev = tx;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Reference frame: header, counts high byte first, XOR of all nine.
  task automatic set_counts(input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] c, input logic [15:0] d);
    logic [15:0] cv[4];
    logic [7:0]  cs;
    count1 = a; count2 = b; count3 = c; count4 = d;
    cv[0] = a; cv[1] = b; cv[2] = c; cv[3] = d;
    exp_f[0] = 8'hA5;
    for (int i = 0; i < 4; i++) begin
      exp_f[1 + 2*i] = 8'(cv[i] / 256);
      exp_f[2 + 2*i] = 8'(cv[i] % 256);
    end
    cs = 8'd0;
    for (int i = 0; i < 9; i++) cs = cs ^ exp_f[i];
    exp_f[9] = cs;
  endtask

  task automatic apply_reset();
    en_count = 1'b0;
    rst = 1'b1;
    ticks(3);
    rst = 1'b0;
    ticks(3);
  endtask

  task automatic raise_gate();
    en_count = 1'b1;
    ticks(3);
    check("rise_ignored", busy, 1'b0);
  endtask

  // Called right after tick(): the fall is sampled at the next rising edge.
  task automatic drop_gate(output int e);
    en_count = 1'b0;
    e = pcyc + 1;
  endtask

  task automatic wait_done(input int nd, input string tag);
    int k;
    k = 0;
    while (done_cnt == nd && k < 1500) begin
      tick();
      k++;
    end
    check({tag, "_done_seen"}, done_cnt, nd + 1);
  endtask

  task automatic verify_frame(input string tag, input int nb, input int ns, input int e);
    check({tag, "_nbytes"}, byte_q.size() - nb, 10);
    if (byte_q.size() >= nb + 10)
      for (int i = 0; i < 10; i++)
        check($sformatf("%s_byte%0d", tag, i), byte_q[nb + i], exp_f[i]);
    check({tag, "_nstarts"}, start_q.size() - ns, 10);
    if (start_q.size() >= ns + 10) begin
      check({tag, "_first_start"}, start_q[ns], e + 2);
      for (int k = 1; k < 10; k++)
        check($sformatf("%s_spacing%0d", tag, k), start_q[ns + k] - start_q[ns + k - 1], 100);
      check({tag, "_frame_len"}, done_t - start_q[ns], 1000);
    end
    check({tag, "_stop_bits"}, stop_err, 0);
  endtask

  task automatic run_frame(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] c, input logic [15:0] d, input bit freeze);
    int nb, ns, nd, e;
    set_counts(a, b, c, d);
    raise_gate();
    nb = byte_q.size(); ns = start_q.size(); nd = done_cnt;
    drop_gate(e);
    tick();
    check({tag, "_busy_at_fall"}, busy, 1'b1);
    if (freeze) begin
      while (pcyc < e + 4) tick();
      count1 = 16'hFFFF; count2 = 16'hFFFF; count3 = 16'hFFFF; count4 = 16'hFFFF;
    end
    wait_done(nd, tag);
    check({tag, "_done_high"}, frame_done, 1'b1);
    check({tag, "_busy_clear"}, busy, 1'b0);
    tick();
    check({tag, "_done_one_cycle"}, frame_done, 1'b0);
    verify_frame(tag, nb, ns, e);
  endtask

  initial begin : main
    int nb, ns, nd, e, x;
    rst = 1'b1;
    en_count = 1'b0;
    count1 = 16'd0; count2 = 16'd0; count3 = 16'd0; count4 = 16'd0;
    ticks(3);
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", frame_done, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    rst = 1'b0;
    ticks(50);
    check("low_at_release_busy", busy, 1'b0);
    check("low_at_release_starts", start_q.size(), 0);

    // Nominal, checksum and snapshot-freeze frames.
    run_frame("nom", 16'd250, 16'd250, 16'd250, 16'd250, 1'b0);
    check("nom_overrun", overrun, 1'b0);
    run_frame("csum", 16'h1234, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    run_frame("freeze", 16'h0102, 16'h0304, 16'h0506, 16'h0708, 1'b1);

    // Overrun: second gate closure 200 clks into the frame is dropped.
    set_counts(16'($urandom()), 16'($urandom()), 16'($urandom()), 16'($urandom()));
    raise_gate();
    nb = byte_q.size(); ns = start_q.size(); nd = done_cnt;
    drop_gate(e);
    tick();
    while (pcyc < e + 200) tick();
    en_count = 1'b1;
    tick();
    en_count = 1'b0;
    ticks(2);
    check("ovr_flag", overrun, 1'b1);
    check("ovr_busy", busy, 1'b1);
    wait_done(nd, "ovr");
    verify_frame("ovr", nb, ns, e);
    ticks(1200);
    check("ovr_single_frame", done_cnt, nd + 1);
    check("ovr_no_extra_bytes", byte_q.size(), nb + 10);
    check("ovr_sticky", overrun, 1'b1);
    apply_reset();
    check("ovr_cleared_by_rst", overrun, 1'b0);

    // Reset during byte 4 aborts the frame at once.
    set_counts(16'($urandom()), 16'($urandom()), 16'($urandom()), 16'($urandom()));
    raise_gate();
    nd = done_cnt;
    drop_gate(e);
    tick();
    while (pcyc < e + 2 + 400 + 3) tick();
    rst = 1'b1;
    #1;
    check("abort_tx", tx, 1'b1);
    check("abort_busy", busy, 1'b0);
    check("abort_done", frame_done, 1'b0);
    ticks(3);
    rst = 1'b0;
    ticks(5);
    check("abort_no_done", done_cnt, nd);
    run_frame("after_rst", 16'($urandom()), 16'($urandom()), 16'($urandom()), 16'($urandom()), 1'b0);

    // Gate falls on the frame_done edge: still busy, so dropped.
    set_counts(16'hBEEF, 16'h0001, 16'h8000, 16'h7FFF);
    raise_gate();
    nb = byte_q.size(); ns = start_q.size(); nd = done_cnt;
    drop_gate(e);
    x = e + 2 + 1000;
    tick();
    while (pcyc < e + 300) tick();
    en_count = 1'b1;
    while (pcyc < x - 1) tick();
    en_count = 1'b0;
    tick();
    check("edge_same_done", frame_done, 1'b1);
    check("edge_same_overrun", overrun, 1'b1);
    verify_frame("edge_same", nb, ns, e);
    ticks(1200);
    check("edge_same_single", done_cnt, nd + 1);
    check("edge_same_starts", start_q.size(), ns + 10);
    apply_reset();

    // Gate falls one cycle after frame_done: accepted as a new frame.
    raise_gate();
    nb = byte_q.size(); ns = start_q.size(); nd = done_cnt;
    drop_gate(e);
    x = e + 2 + 1000;
    tick();
    while (pcyc < e + 300) tick();
    en_count = 1'b1;
    while (pcyc < x) tick();
    en_count = 1'b0;
    verify_frame("edge_next_a", nb, ns, e);
    wait_done(nd + 1, "edge_next_b");
    verify_frame("edge_next_b", nb + 10, ns + 10, x + 1);
    check("edge_next_overrun", overrun, 1'b0);

    // Randomized counts, some with counts changing mid-frame.
    for (int r = 0; r < 4; r++) begin
      run_frame($sformatf("rnd%0d", r), 16'($urandom()), 16'($urandom()),
                16'($urandom()), 16'($urandom()), 1'($urandom_range(0, 1)));
    end
    check("final_overrun", overrun, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
